// File: rtl/cache_tag_controller_if.sv
// cache_tag_controller_if: command, response and statistics bundle of the tag controller
interface cache_tag_controller_if #(
  parameter int indexBits = 14,
  parameter int tagBits = 12,
  parameter int wayBits = 3,
  parameter int countBits = 32
);
  logic cmdValid;
  logic cmdReady;
  logic [3:0] cmd;
  logic [tagBits-1:0] addressTag;
  logic [indexBits-1:0] index;
  logic respValid;
  logic hit;
  logic [wayBits-1:0] hitWay;
  logic evict;
  logic [tagBits-1:0] evictTag;
  logic [countBits-1:0] readCount;
  logic [countBits-1:0] writeCount;
  logic [countBits-1:0] hitCount;
  logic [countBits-1:0] missCount;
  modport master (
    output cmdValid, cmd, addressTag, index,
    input cmdReady, respValid, hit, hitWay, evict, evictTag,
    input readCount, writeCount, hitCount, missCount
  );
  modport slave (
    input cmdValid, cmd, addressTag, index,
    output cmdReady, respValid, hit, hitWay, evict, evictTag,
    output readCount, writeCount, hitCount, missCount
  );
endinterface

// File: rtl/cache_tag_controller.sv
// cache_tag_controller: set-associative tag lookup with true-LRU replacement and access statistics
module cache_tag_controller #(
  parameter int indexBits = 14,
  parameter int tagBits = 12,
  parameter int ways = 8,
  parameter int wayBits = 3,
  parameter int countBits = 32
) (
  input logic clk,
  input logic resetN,
  cache_tag_controller_if.slave bus
);
  localparam int sets = 1 << indexBits;
  typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE, RESP} state_t;
  function automatic logic [ways-1:0][wayBits-1:0] lru_init();
    logic [ways-1:0][wayBits-1:0] r;
    for (int w = 0; w < ways; w++) r[w] = wayBits'(w);
    return r;
  endfunction
  function automatic logic [countBits-1:0] sat(input logic [countBits-1:0] x);
    return &x ? x : x + 1'b1;
  endfunction
  localparam logic [ways-1:0][wayBits-1:0] lru_reset = lru_init();
  state_t state;
  logic [3:0] cmd_r;
  logic [tagBits-1:0] tag_r;
  logic [indexBits-1:0] idx_r;
  logic [tagBits-1:0] tag_mem [sets][ways];
  logic [ways-1:0] valid_mem [sets];
  logic [ways-1:0] dirty_mem [sets];
  logic [ways-1:0][wayBits-1:0] lru_mem [sets];
  // A set whose fresh bit is still set reads as just-reset (all invalid, LRU = way number),
  // so reset only has to touch one bit per set instead of every row.
  logic [sets-1:0] fresh;
  logic lk_hit, lk_ev, hit_c, inv_c, acc;
  logic [wayBits-1:0] lk_way, hit_way_c, inv_way_c, old_way_c, vic_c;
  logic [tagBits-1:0] lk_etag;
  logic [ways-1:0] v_row, d_row, nv, nd;
  logic [ways-1:0][wayBits-1:0] l_row, nl;
  assign acc = cmd_r <= 4'd2;
  // Read the addressed set, find hit and victim ways, and build the row to write back
  always_comb begin
    v_row = fresh[idx_r] ? '0 : valid_mem[idx_r];
    d_row = fresh[idx_r] ? '0 : dirty_mem[idx_r];
    l_row = fresh[idx_r] ? lru_reset : lru_mem[idx_r];
    hit_c = 1'b0;
    hit_way_c = '0;
    inv_c = 1'b0;
    inv_way_c = '0;
    old_way_c = '0;
    for (int w = ways - 1; w >= 0; w--) begin
      if (!v_row[w]) begin
        inv_c = 1'b1;
        inv_way_c = wayBits'(w);
      end
      if (v_row[w] && tag_mem[idx_r][w] == tag_r) begin
        hit_c = 1'b1;
        hit_way_c = wayBits'(w);
      end
      if (l_row[w] == wayBits'(ways - 1)) old_way_c = wayBits'(w);
    end
    vic_c = inv_c ? inv_way_c : old_way_c;
    nv = v_row;
    nd = d_row;
    nl = l_row;
    if (acc) begin
      nv[lk_way] = 1'b1;
      nd[lk_way] = (lk_hit & d_row[lk_way]) | (cmd_r == 4'd1);
      for (int w = 0; w < ways; w++) nl[w] = l_row[w] < l_row[lk_way] ? l_row[w] + 1'b1 : l_row[w];
      nl[lk_way] = '0;
    end else if (cmd_r == 4'd3 && lk_hit) begin
      nv[lk_way] = 1'b0;
      nd[lk_way] = 1'b0;
    end
  end
  // Commit the updated set row; tags only change when a line is allocated
  always_ff @(posedge clk) begin
    if (state == UPDATE) begin
      valid_mem[idx_r] <= nv;
      dirty_mem[idx_r] <= nd;
      lru_mem[idx_r] <= nl;
      if (acc && !lk_hit) tag_mem[idx_r][lk_way] <= tag_r;
    end
  end
  // Command FSM with registered response, handshake and statistics
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
      bus.cmdReady <= 1'b1;
      bus.respValid <= 1'b0;
      bus.hit <= 1'b0;
      bus.hitWay <= '0;
      bus.evict <= 1'b0;
      bus.evictTag <= '0;
      bus.readCount <= '0;
      bus.writeCount <= '0;
      bus.hitCount <= '0;
      bus.missCount <= '0;
      cmd_r <= '0;
      tag_r <= '0;
      idx_r <= '0;
      lk_hit <= 1'b0;
      lk_ev <= 1'b0;
      lk_way <= '0;
      lk_etag <= '0;
      fresh <= '1;
    end else begin
      bus.respValid <= 1'b0;
      case (state)
        IDLE: if (bus.cmdValid) begin
          cmd_r <= bus.cmd;
          tag_r <= bus.addressTag;
          idx_r <= bus.index;
          bus.cmdReady <= 1'b0;
          state <= bus.cmd == 4'd8 ? RESP : LOOKUP;
          if (bus.cmd == 4'd8) begin
            bus.readCount <= '0;
            bus.writeCount <= '0;
            bus.hitCount <= '0;
            bus.missCount <= '0;
            bus.hit <= 1'b0;
            bus.evict <= 1'b0;
            bus.evictTag <= '0;
          end
        end
        LOOKUP: begin
          lk_hit <= hit_c;
          lk_way <= hit_c ? hit_way_c : vic_c;
          lk_ev <= !hit_c && v_row[vic_c] && d_row[vic_c];
          lk_etag <= tag_mem[idx_r][vic_c];
          state <= UPDATE;
        end
        UPDATE: begin
          bus.hit <= (acc || cmd_r == 4'd3) && lk_hit;
          bus.hitWay <= lk_way;
          bus.evict <= acc && lk_ev;
          bus.evictTag <= acc && lk_ev ? lk_etag : '0;
          fresh[idx_r] <= 1'b0;
          if (acc) begin
            if (cmd_r == 4'd1) bus.writeCount <= sat(bus.writeCount);
            else bus.readCount <= sat(bus.readCount);
            if (lk_hit) bus.hitCount <= sat(bus.hitCount);
            else bus.missCount <= sat(bus.missCount);
          end
          state <= RESP;
        end
        default: begin
          bus.respValid <= 1'b1;
          bus.cmdReady <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cache_tag_controller.sv
// tb_cache_tag_controller: directed and random checks of the tag controller against a recency-list model
module tb_cache_tag_controller;
  localparam int IB = 14, TBITS = 12, WAYS = 8, WB = 3, CB = 32, NS = 5;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;
  cache_tag_controller_if #(.indexBits(IB), .tagBits(TBITS), .wayBits(WB), .countBits(CB)) bus ();
  cache_tag_controller #(.indexBits(IB), .tagBits(TBITS), .ways(WAYS), .wayBits(WB), .countBits(CB)) dut (
    .clk(clk), .resetN(resetN), .bus(bus)
  );
  int n_tests = 0;
  int n_fail = 0;
  int idx_tab [NS] = '{5, 7, 3, 2, 16383};
  logic [TBITS-1:0] m_tag [NS][WAYS];
  bit m_v [NS][WAYS];
  bit m_d [NS][WAYS];
  int m_ord [NS][$];
  longint m_rd, m_wr, m_hit, m_miss;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, exp);
    end
  endtask
  function automatic longint sat(input longint x);
    return x == 64'hFFFF_FFFF ? x : x + 1;
  endfunction
  function automatic void m_reset();
    for (int s = 0; s < NS; s++) begin
      m_ord[s] = {};
      for (int w = 0; w < WAYS; w++) begin
        m_v[s][w] = 0;
        m_d[s][w] = 0;
        m_tag[s][w] = '0;
        m_ord[s].push_back(w);
      end
    end
    m_rd = 0; m_wr = 0; m_hit = 0; m_miss = 0;
  endfunction
  // recency list: front = most recently used, back = replacement candidate
  function automatic void touch(input int s, input int w);
    for (int i = 0; i < m_ord[s].size(); i++)
      if (m_ord[s][i] == w) begin
        m_ord[s].delete(i);
        break;
      end
    m_ord[s].push_front(w);
  endfunction
  task automatic chk_counts(input string pfx);
    chk({pfx, "_readCount"}, bus.readCount, m_rd);
    chk({pfx, "_writeCount"}, bus.writeCount, m_wr);
    chk({pfx, "_hitCount"}, bus.hitCount, m_hit);
    chk({pfx, "_missCount"}, bus.missCount, m_miss);
  endtask
  task automatic do_cmd(input logic [3:0] c, input logic [TBITS-1:0] t, input int s);
    bit e_hit = 0, e_ev = 0, way_known = 0;
    int e_way = 0, h = -1, lat = 0;
    logic [TBITS-1:0] e_etag = '0;
    for (int w = 0; w < WAYS; w++) if (m_v[s][w] && m_tag[s][w] == t) h = w;
    if (c == 4'd8) begin
      m_rd = 0; m_wr = 0; m_hit = 0; m_miss = 0;
    end else if (c <= 4'd2) begin
      if (h >= 0) begin
        e_hit = 1;
        e_way = h;
        if (c == 4'd1) m_d[s][h] = 1;
      end else begin
        e_way = m_ord[s][m_ord[s].size() - 1];
        for (int w = WAYS - 1; w >= 0; w--) if (!m_v[s][w]) e_way = w;
        e_ev = m_v[s][e_way] && m_d[s][e_way];
        e_etag = m_tag[s][e_way];
        m_v[s][e_way] = 1;
        m_d[s][e_way] = c == 4'd1;
        m_tag[s][e_way] = t;
      end
      way_known = 1;
      touch(s, e_way);
      if (c == 4'd1) m_wr = sat(m_wr);
      else m_rd = sat(m_rd);
      if (e_hit) m_hit = sat(m_hit);
      else m_miss = sat(m_miss);
    end else if (c == 4'd3 && h >= 0) begin
      e_hit = 1;
      e_way = h;
      way_known = 1;
      m_v[s][h] = 0;
      m_d[s][h] = 0;
    end
    @(negedge clk);
    chk("ready_idle", bus.cmdReady, 1);
    bus.cmdValid = 1'b1;
    bus.cmd = c;
    bus.addressTag = t;
    bus.index = IB'(idx_tab[s]);
    @(posedge clk);
    #1;
    bus.cmdValid = 1'b0;
    bus.cmd = 4'($urandom);
    bus.addressTag = TBITS'($urandom);
    bus.index = IB'($urandom);
    while (!bus.respValid && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
      if (!bus.respValid) chk("busy_ready", bus.cmdReady, 0);
    end
    chk("latency", lat, c == 4'd8 ? 1 : 3);
    chk("hit", bus.hit, e_hit);
    if (way_known) chk("hitWay", bus.hitWay, e_way);
    chk("evict", bus.evict, e_ev);
    if (e_ev) chk("evictTag", bus.evictTag, e_etag);
    chk_counts("resp");
    chk("ready_resp", bus.cmdReady, 1);
    @(posedge clk);
    #1;
    chk("resp_pulse", bus.respValid, 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    logic [3:0] c;
    int r;
    bus.cmdValid = 1'b0;
    bus.cmd = '0;
    bus.addressTag = '0;
    bus.index = '0;
    m_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetN = 1'b1;
    #1;
    chk("rst_ready", bus.cmdReady, 1);
    chk("rst_respValid", bus.respValid, 0);
    chk("rst_hit", bus.hit, 0);
    chk("rst_hitWay", bus.hitWay, 0);
    chk("rst_evict", bus.evict, 0);
    chk("rst_evictTag", bus.evictTag, 0);
    chk_counts("rst");
    do_cmd(4'd0, 12'h123, 0);
    chk("t1_hit", bus.hit, 0);
    chk("t1_hitWay", bus.hitWay, 0);
    chk("t1_evict", bus.evict, 0);
    do_cmd(4'd0, 12'h123, 0);
    chk("t2_hit", bus.hit, 1);
    chk("t2_hitWay", bus.hitWay, 0);
    chk("t2_readCount", bus.readCount, 2);
    chk("t2_hitCount", bus.hitCount, 1);
    chk("t2_missCount", bus.missCount, 1);
    for (int i = 1; i <= 8; i++) do_cmd(4'd1, 12'(i), 1);
    do_cmd(4'd0, 12'd9, 1);
    chk("lru_hit", bus.hit, 0);
    chk("lru_hitWay", bus.hitWay, 0);
    chk("lru_evict", bus.evict, 1);
    chk("lru_evictTag", bus.evictTag, 1);
    do_cmd(4'd0, 12'd2, 1);
    chk("lru2_hit", bus.hit, 1);
    chk("lru2_hitWay", bus.hitWay, 1);
    do_cmd(4'd0, 12'h055, 2);
    do_cmd(4'd3, 12'h055, 2);
    chk("inv_hit", bus.hit, 1);
    chk("inv_hitWay", bus.hitWay, 0);
    do_cmd(4'd0, 12'h055, 2);
    chk("inv2_hit", bus.hit, 0);
    chk("inv2_hitWay", bus.hitWay, 0);
    chk("inv2_evict", bus.evict, 0);
    do_cmd(4'd8, 12'h000, 0);
    chk("clr_readCount", bus.readCount, 0);
    chk("clr_missCount", bus.missCount, 0);
    do_cmd(4'd5, 12'h123, 0);
    chk("nop_hit", bus.hit, 0);
    chk("nop_readCount", bus.readCount, 0);
    @(negedge clk);
    bus.cmdValid = 1'b1;
    bus.cmd = 4'd0;
    bus.addressTag = 12'hABC;
    bus.index = IB'(idx_tab[3]);
    @(posedge clk);
    #1;
    bus.cmdValid = 1'b0;
    #2;
    resetN = 1'b0;
    #1;
    m_reset();
    chk("mid_ready", bus.cmdReady, 1);
    chk("mid_respValid", bus.respValid, 0);
    chk_counts("mid");
    @(negedge clk);
    @(negedge clk);
    resetN = 1'b1;
    do_cmd(4'd0, 12'hABC, 3);
    chk("mid_rehit", bus.hit, 0);
    repeat (400) begin
      r = $urandom_range(0, 19);
      c = r < 6 ? 4'd0 : r < 11 ? 4'd1 : r < 14 ? 4'd2 : r < 17 ? 4'd3 : r == 17 ? 4'd8 :
          r == 18 ? 4'($urandom_range(9, 15)) : 4'($urandom_range(4, 7));
      do_cmd(c, 12'($urandom_range(0, 11)), $urandom_range(0, NS - 1));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
